// File: rtl/feat_pkg.sv
// Shared defaults and types for the feature-vector transmit path into DP_main.
package feat_pkg;
    localparam int FEAT_DW       = 32;
    localparam int FEAT_NUM_COEF = 12;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;

    typedef logic signed [FEAT_DW-1:0] coef_t;
endpackage

// File: rtl/feat_pingpong_buf.sv
// Two-bank frame store: one bank fills while the other is replayed; reads are combinational.
module feat_pingpong_buf #(
    parameter int NUM_COEF = 12,
    parameter int DW       = 32,
    parameter int IW       = $clog2(NUM_COEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic          i_wb,
    input  logic [IW-1:0] i_wi,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_wflag,
    input  logic          i_rb,
    input  logic [IW-1:0] i_ri,
    output logic [DW-1:0] o_rdata,
    output logic          o_rflag
);
    logic [DW-1:0] r_mem [2][NUM_COEF];
    logic [1:0]    r_flag;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wb][i_wi] <= i_wdata;
    end

    // The vad flag belongs to the frame, so it is captured only with word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= '0;
        end else if (i_we && i_wi == '0) begin
            r_flag[i_wb] <= i_wflag;
        end
    end

    assign o_rdata = r_mem[i_rb][i_ri];
    assign o_rflag = r_flag[i_rb];
endmodule

// File: rtl/feat_frame_tx.sv
// Frame transmitter: collects NUM_COEF coefficients per frame into a ping-pong buffer and
// replays each complete frame as dv-strobed words separated by GAP idle cycles.
module feat_frame_tx
    import feat_pkg::*;
#(
    parameter int NUM_COEF = FEAT_NUM_COEF,
    parameter int DW       = FEAT_DW,
    parameter int GAP      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] coef_in,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic          vad_in,
    input  logic          flush,
    output logic [DW-1:0] vec_out,
    output logic          dv_out,
    output logic          vad_out,
    output logic          busy
);
    localparam int            IW       = $clog2(NUM_COEF);
    localparam logic [IW-1:0] LAST     = IW'(NUM_COEF - 1);
    localparam logic [2:0]    GAP_LAST = 3'(GAP - 1);

    tx_state_t     r_state, w_state_nxt;
    logic [1:0]    r_full, w_full_nxt;
    logic          r_wb, w_wb_nxt;
    logic          r_rb, w_rb_nxt;
    logic [IW-1:0] r_wi, r_ri, w_ri_nxt;
    logic [2:0]    r_gcnt, w_gcnt_nxt;
    logic          w_we, w_wlast, w_release;
    logic [DW-1:0] w_rd_data;
    logic          w_rd_flag;
    logic          r_ready, r_dv, r_vad, r_busy;
    logic [DW-1:0] r_vec;
    logic          w_dv_d, w_vad_d, w_busy_d;
    logic [DW-1:0] w_vec_d;

    feat_pingpong_buf #(
        .NUM_COEF(NUM_COEF),
        .DW      (DW),
        .IW      (IW)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_we   (w_we),
        .i_wb   (r_wb),
        .i_wi   (r_wi),
        .i_wdata(coef_in),
        .i_wflag(vad_in),
        .i_rb   (r_rb),
        .i_ri   (r_ri),
        .o_rdata(w_rd_data),
        .o_rflag(w_rd_flag)
    );

    // Flush wins over a same-cycle transfer, whose word is dropped.
    assign w_we     = coef_valid && r_ready && !flush;
    assign w_wlast  = w_we && (r_wi == LAST);
    assign w_wb_nxt = r_wb ^ w_wlast;

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rb] = 1'b0;
        if (w_wlast)   w_full_nxt[r_wb] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full  <= '0;
            r_wb    <= 1'b0;
            r_wi    <= '0;
            r_ready <= 1'b1;
        end else begin
            r_full  <= w_full_nxt;
            r_wb    <= w_wb_nxt;
            r_ready <= !w_full_nxt[w_wb_nxt];
            if (flush) begin
                r_wi <= '0;
            end else if (w_we) begin
                r_wi <= w_wlast ? '0 : r_wi + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_rb    <= 1'b0;
            r_ri    <= '0;
            r_gcnt  <= '0;
            r_dv    <= 1'b0;
            r_vec   <= '0;
            r_vad   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rb    <= w_rb_nxt;
            r_ri    <= w_ri_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_dv    <= w_dv_d;
            r_vec   <= w_vec_d;
            r_vad   <= w_vad_d;
            r_busy  <= w_busy_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rb_nxt    = r_rb;
        w_ri_nxt    = r_ri;
        w_gcnt_nxt  = r_gcnt;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rb]) begin
                    w_state_nxt = ST_SEND;
                    w_ri_nxt    = '0;
                end
            end
            ST_SEND: begin
                if (r_ri == LAST) begin
                    w_release = 1'b1;
                    w_rb_nxt  = !r_rb;
                    w_ri_nxt  = '0;
                    // Only a zero-gap link chains frames without the idle cycle.
                    w_state_nxt = (GAP == 0 && r_full[!r_rb]) ? ST_SEND : ST_IDLE;
                end else begin
                    w_ri_nxt    = r_ri + 1'b1;
                    w_gcnt_nxt  = '0;
                    w_state_nxt = (GAP == 0) ? ST_SEND : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gcnt == GAP_LAST) w_state_nxt = ST_SEND;
                else                    w_gcnt_nxt  = r_gcnt + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_dv_d   = (r_state == ST_SEND);
        w_vec_d  = w_dv_d ? w_rd_data : r_vec;
        w_vad_d  = (w_dv_d && r_ri == '0) ? w_rd_flag : r_vad;
        w_busy_d = (w_state_nxt != ST_IDLE);
    end

    assign coef_ready = r_ready;
    assign vec_out    = r_vec;
    assign dv_out     = r_dv;
    assign vad_out    = r_vad;
    assign busy       = r_busy;
endmodule

// File: tb/tb_feat_frame_tx.sv
// Directed bench for feat_frame_tx: GAP=1 instance for framing/flush/reset cases, GAP=0 for streaming.
module tb_feat_frame_tx;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        reset, coef_valid, vad_in, flush, coef_ready, dv_out, vad_out, busy;
    logic [31:0] coef_in, vec_out;
    logic        rst0, c0_valid, c0_vad, c0_flush, v0_rdy, v0_dv, v0_vad, v0_busy;
    logic [31:0] c0_in, v0_vec;

    feat_frame_tx #(.NUM_COEF(12), .DW(32), .GAP(1)) u_dut (
        .clk(clk), .reset(reset), .coef_in(coef_in), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .vad_in(vad_in), .flush(flush), .vec_out(vec_out),
        .dv_out(dv_out), .vad_out(vad_out), .busy(busy)
    );

    feat_frame_tx #(.NUM_COEF(12), .DW(32), .GAP(0)) u_dut0 (
        .clk(clk), .reset(rst0), .coef_in(c0_in), .coef_valid(c0_valid),
        .coef_ready(v0_rdy), .vad_in(c0_vad), .flush(c0_flush), .vec_out(v0_vec),
        .dv_out(v0_dv), .vad_out(v0_vad), .busy(v0_busy)
    );

    int     n_run = 0, n_fail = 0;
    longint qv[$], q0v[$];
    bit     qvad[$], q0vad[$];
    int     qc[$], q0c[$];
    int     busy_tot = 0, nrdy_tot = 0;
    int     last_acc = 0, last_acc0 = 0;

    always @(negedge clk) begin
        if (dv_out) begin
            qv.push_back(longint'($signed(vec_out)));
            qvad.push_back(vad_out);
            qc.push_back(cyc);
        end
        if (v0_dv) begin
            q0v.push_back(longint'($signed(v0_vec)));
            q0vad.push_back(v0_vad);
            q0c.push_back(cyc);
        end
        if (busy) busy_tot++;
        if (!coef_ready) nrdy_tot++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic v);
        int guard = 0;
        coef_in = d; vad_in = v; coef_valid = 1'b1;
        while (!coef_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!coef_ready) chk("push_ready_timeout", coef_ready, 1);
        @(posedge clk); #1;
        coef_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic push0(input logic [31:0] d, input logic v);
        int guard = 0;
        c0_in = d; c0_vad = v; c0_valid = 1'b1;
        while (!v0_rdy && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!v0_rdy) chk("push0_ready_timeout", v0_rdy, 1);
        @(posedge clk); #1;
        c0_valid = 1'b0;
        last_acc0 = cyc;
    endtask

    task automatic wait_n(input string tag, input int base, input int n, input int budget);
        int k = 0;
        while (qv.size() < base + n && k < budget) begin @(posedge clk); #1; k++; end
        chk(tag, qv.size() - base, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base, t_acc, b0, r0, k;
        reset = 1'b0; coef_in = '0; coef_valid = 1'b0; vad_in = 1'b0; flush = 1'b0;
        rst0  = 1'b0; c0_in = '0; c0_valid = 1'b0; c0_vad = 1'b0; c0_flush = 1'b0;
        #12;
        chk("rst_vec", vec_out, 0);
        chk("rst_dv", dv_out, 0);
        chk("rst_vad", vad_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", coef_ready, 1);
        chk("rst_ready_gap0", v0_rdy, 1);
        @(posedge clk); #1;
        reset = 1'b1; rst0 = 1'b1;
        @(posedge clk); #1;

        // single frame -6..5, vad=1
        base = qv.size(); b0 = busy_tot;
        for (int i = 0; i < 12; i++) push(32'(i - 6), 1'b1);
        t_acc = last_acc;
        wait_n("t1_count", base, 12, 100);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) chk($sformatf("t1_vec%0d", i), qv[base+i], i - 6);
        chk("t1_first_latency", qc[base] - t_acc, 2);
        chk("t1_spacing", qc[base+1] - qc[base], 2);
        chk("t1_span", qc[base+11] - qc[base], 22);
        chk("t1_vad_first", qvad[base], 1);
        chk("t1_busy_cycles", busy_tot - b0, 23);
        chk("t1_vec_hold", longint'($signed(vec_out)), 5);
        chk("t1_dv_idle", dv_out, 0);
        chk("t1_vad_hold", vad_out, 1);
        chk("t1_busy_idle", busy, 0);

        // three frames back to back, vad 1/0/1
        base = qv.size(); r0 = nrdy_tot;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 12; i++) push(32'(f * 256 + i), f != 1);
        wait_n("t2_count", base, 36, 300);
        repeat (6) @(posedge clk);
        #1;
        chk("t2_total", qv.size() - base, 36);
        chk("t2_ready_dropped", nrdy_tot > r0, 1);
        for (int i = 0; i < 36; i++)
            chk($sformatf("t2_vec%0d", i), qv[base+i], (i / 12) * 256 + (i % 12));
        chk("t2_vad_f0", qvad[base], 1);
        chk("t2_vad_f1", qvad[base+12], 0);
        chk("t2_vad_f1_end", qvad[base+23], 0);
        chk("t2_vad_f2", qvad[base+24], 1);
        chk("t2_gap_ab", qc[base+12] - qc[base+11], 2);
        chk("t2_gap_bc", qc[base+24] - qc[base+23], 2);

        // flush after 5 words, flush coincides with an offered word
        base = qv.size();
        for (int i = 0; i < 5; i++) push(32'h50 + 32'(i), 1'b1);
        coef_in = 32'h99; vad_in = 1'b1; coef_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; coef_valid = 1'b0;
        for (int i = 0; i < 12; i++) push(32'h60 + 32'(i), 1'b0);
        wait_n("t3_count", base, 12, 100);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_total", qv.size() - base, 12);
        chk("t3_first", qv[base], 32'h60);
        chk("t3_last", qv[base+11], 32'h6B);
        chk("t3_vad_pulse", qvad[base], 0);
        chk("t3_vad_out", vad_out, 0);

        // writer fills bank 1 on the very edge the reader releases bank 0
        reset = 1'b0; #2; reset = 1'b1;
        @(posedge clk); #1;
        base = qv.size();
        for (int i = 0; i < 12; i++) push(32'hA00 + 32'(i), 1'b1);
        t_acc = last_acc;
        for (int i = 0; i < 11; i++) push(32'hB00 + 32'(i), 1'b0);
        while (cyc < t_acc + 23) begin @(posedge clk); #1; end
        push(32'hB0B, 1'b0);
        chk("t4_ready_after_swap", coef_ready, 1);
        wait_n("t4_count", base, 24, 150);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_total", qv.size() - base, 24);
        chk("t4_a_last_time", qc[base+11] - t_acc, 24);
        chk("t4_b_first_time", qc[base+12] - t_acc, 26);
        chk("t4_a_last", qv[base+11], 32'hA0B);
        chk("t4_b_first", qv[base+12], 32'hB00);
        chk("t4_b_last", qv[base+23], 32'hB0B);
        chk("t4_b_vad", qvad[base+12], 0);
        chk("t4_busy_end", busy, 0);
        chk("t4_ready_end", coef_ready, 1);

        // reset during pulse 7
        base = qv.size();
        for (int i = 0; i < 12; i++) push(32'hC00 + 32'(i), 1'b1);
        k = 0;
        while (!(dv_out && qv.size() == base + 6) && k < 100) begin @(posedge clk); #1; k++; end
        chk("t5_dv_at_pulse7", dv_out, 1);
        chk("t5_vec_at_pulse7", vec_out, 32'hC06);
        reset = 1'b0;
        #1;
        chk("t5_dv_async", dv_out, 0);
        chk("t5_vad_async", vad_out, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_vec_async", vec_out, 0);
        chk("t5_ready_async", coef_ready, 1);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready_release", coef_ready, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_resume", qv.size() - base, 6);
        for (int i = 0; i < 12; i++) push(32'hD00 + 32'(i), 1'b0);
        wait_n("t5_count", base + 6, 12, 100);
        chk("t5_first", qv[base+6], 32'hD00);
        chk("t5_last", qv[base+17], 32'hD0B);
        chk("t5_vad", qvad[base+6], 0);

        // GAP=0 instance, two frames streamed
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 12; i++) begin
                push0((f == 0) ? 32'h300 + 32'(i) : 32'(-(i + 1)), f == 0);
                if (f == 0 && i == 11) t_acc = last_acc0;
            end
        k = 0;
        while (q0v.size() < 24 && k < 100) begin @(posedge clk); #1; k++; end
        repeat (5) @(posedge clk);
        #1;
        chk("t6_count", q0v.size(), 24);
        for (int i = 0; i < 24; i++)
            chk($sformatf("t6_vec%0d", i), q0v[i], (i < 12) ? longint'(32'h300 + i) : -(i - 12 + 1));
        chk("t6_latency", q0c[0] - t_acc, 2);
        chk("t6_contiguous", q0c[23] - q0c[0], 23);
        chk("t6_vad_f0", q0vad[0], 1);
        chk("t6_vad_f1", q0vad[12], 0);
        chk("t6_busy_end", v0_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/feat_frame_tx.md
Name: feat_frame_tx

Overview:
- Transmit side of the feature-vector link into DP_main.
- Accepts feature coefficients over a valid/ready stream and collects each frame of NUM_COEF words into a ping-pong buffer.
- Replays each complete frame on the vec/dv strobe protocol: one-cycle dv pulse per word, GAP idle cycles between pulses, with a per-frame vad flag.
- Sits between the feature extractor (MFCC stage) and DP_main.

Parameters:
- NUM_COEF, 12, coefficients per frame (2..16).
- DW, 32, coefficient width, signed two's complement.
- GAP, 1, idle cycles between consecutive dv pulses within a frame (0..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- coef_in  in  DW  signed coefficient from extractor.
- coef_valid  in  1  coef_in valid this cycle.
- coef_ready  out  1  block can accept coef_in; transfer occurs when valid && ready.
- vad_in  in  1  voice flag; sampled with the first coefficient of each frame.
- flush  in  1  synchronous; discards the partially written frame.
- vec_out  out  DW  signed coefficient; held stable between pulses.
- dv_out  out  1  one-cycle strobe; vec_out valid while high.
- vad_out  out  1  vad flag of the frame most recently started on output.
- busy  out  1  a frame is being transmitted.

Behaviour:
- Reset (reset=0, async): vec_out=0, dv_out=0, vad_out=0, busy=0, coef_ready=1, both banks empty, write bank=0, read bank=0, counters=0, FSM=IDLE.
- All outputs are registered.

Write side:
- Write index wi counts 0..NUM_COEF-1.
- On each transfer, store coef_in into bank[wb][wi]; on wi==0 also store vad_in as that bank's vad flag.
- On the transfer with wi==NUM_COEF-1: set full[wb], toggle wb, reset wi to 0.
- coef_ready = !full[wb], registered, so it deasserts the cycle after the bank that just filled.
- With both banks full, coef_ready=0 until a bank is released.
- flush=1: wi<=0, the partial frame is discarded, full flags are unaffected. flush takes priority over a same-cycle transfer, whose data is dropped.

Read FSM (IDLE, SEND, GAP):
- IDLE: if full[rb], go to SEND with ri=0, busy=1.
- SEND (one cycle):
  - dv_out=1, vec_out=bank[rb][ri].
  - On ri==0, vad_out<=flag[rb].
  - If ri==NUM_COEF-1: clear full[rb], toggle rb, go to IDLE (if GAP==0 and the other bank is full, go straight to SEND with ri=0).
  - Else ri++, and go to GAP (or SEND if GAP==0).
- GAP: dv_out=0, count GAP cycles, then SEND.
- Inter-frame spacing: IDLE costs one cycle, so consecutive frames are separated by at least one idle cycle when GAP>=1.

Timing and boundaries:
- Latency: the last coefficient accepted at edge N puts the first dv_out high after edge N+2.
- With GAP=1 a frame occupies 2*NUM_COEF-1 cycles from first to last pulse (23 for default).
- vad_out holds until the next frame's first pulse; it is never cleared between frames.
- vec_out holds its last value while dv_out=0.
- Same-cycle clear of full[rb] by the reader and set of full[wb] by the writer on different banks: both take effect.
- The reader never touches the write bank: wb==rb is only possible while that bank is empty.
- busy=0 in IDLE only.
- Reset asserted mid-frame aborts immediately. No partial-frame output resumes after release.

Decomposition:
- Package feat_pkg: DW, NUM_COEF default, FSM state enum (IDLE/SEND/GAP), coef_t typedef (signed [DW-1:0]).
- One sub-module, feat_pingpong_buf: two NUM_COEF x DW banks plus flags, with write port (wb, wi, data, flag) and read port (rb, ri), combinational read.
- The FSM and handshake stay in the top level.

Test Plan:
- Single frame, coef k = k-6 (-6..5), vad_in=1, GAP=1 → 12 dv pulses spaced 2 cycles; vec_out sequence -6..5; first pulse 2 cycles after last accept; vad_out=1 from first pulse; busy high 23 cycles.
- Back-to-back: three frames streamed continuously (0x0..0xB, 0x100..0x10B, 0x200..0x20B) → coef_ready drops once both banks are full; 36 pulses in order with no loss or duplication; one idle cycle between frames.
- Flush after 5 words of frame A, then full frame B (vad=0) → only B's 12 words are emitted, vad_out=0.
- Simultaneous release/fill: writer completes bank 1 in the same cycle the reader sends the last word of bank 0 → bank 1 is transmitted next, full flags are consistent, no stall.
- Reset pulsed low during pulse 7 of a frame → dv_out, vad_out, busy, vec_out drop to 0 asynchronously; coef_ready=1 after release; next frame transmits from word 0.
- GAP=0 instance: two full frames → 24 consecutive dv cycles with no gap, vec_out correct each cycle.
